// File: rtl/z_packer_pkg.sv
// Shared encodings and constants for the z_packer bit-to-byte packer.
// Holds the RX/TX state types, the packet length and a popcount helper.
package z_packer_pkg;

  localparam int PACKET_LEN = 8;
  localparam int CNT_W      = $clog2(PACKET_LEN);

  typedef enum logic {
    RX_WAIT = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_VALID = 1'b1
  } tx_state_e;

  function automatic logic [3:0] popcount8(input logic [PACKET_LEN-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < PACKET_LEN; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/z_packer_if.sv
// Upstream (dav_/rfd/z) and downstream (dav_out_/rfd_out/out/ones) handshake bundle.
// The master modport is the environment side and the slave modport is the packer side.
interface z_packer_if;
  logic       dav_;
  logic       z;
  logic       rfd;
  logic       dav_out_;
  logic       rfd_out;
  logic [7:0] out;
  logic [3:0] ones;

  modport master (
    output dav_, z, rfd_out,
    input  rfd, dav_out_, out, ones
  );

  modport slave (
    input  dav_, z, rfd_out,
    output rfd, dav_out_, out, ones
  );
endinterface

// File: rtl/z_packer.sv
// Packs eight z results into a byte plus its ones count, behind an output
// buffer so the next packet is collected while the current one is delivered.
module z_packer
  import z_packer_pkg::*;
(
  input  logic  clock,
  input  logic  reset_,
  z_packer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKET_LEN - 1);

  rx_state_e             rx_state_q, rx_state_d;
  tx_state_e             tx_state_q, tx_state_d;
  logic [PACKET_LEN-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic [PACKET_LEN-1:0] out_q, out_d;
  logic [3:0]            ones_q, ones_d;
  logic [PACKET_LEN-1:0] packed_bits;

  assign packed_bits = {sh_q[PACKET_LEN-2:0], bus.z};

  always_comb begin
    rx_state_d = rx_state_q;
    tx_state_d = tx_state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    out_d      = out_q;
    ones_d     = ones_q;

    // TX only clears full and RX only sets it from full_q=0, so the two never collide.
    unique case (tx_state_q)
      TX_IDLE: begin
        if (full_q && bus.rfd_out) begin
          tx_state_d = TX_VALID;
        end
      end
      TX_VALID: begin
        if (!bus.rfd_out) begin
          tx_state_d = TX_IDLE;
          full_d     = 1'b0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    unique case (rx_state_q)
      RX_WAIT: begin
        if (!bus.dav_ && ((cnt_q != LAST_CNT) || !full_q)) begin
          rx_state_d = RX_ACK;
          if (cnt_q == LAST_CNT) begin
            out_d  = packed_bits;
            ones_d = popcount8(packed_bits);
            full_d = 1'b1;
            cnt_d  = '0;
            sh_d   = '0;
          end else begin
            sh_d  = packed_bits;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RX_ACK: begin
        if (bus.dav_) begin
          rx_state_d = RX_WAIT;
        end
      end
      default: rx_state_d = RX_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      rx_state_q <= RX_WAIT;
      tx_state_q <= TX_IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      out_q      <= '0;
      ones_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      out_q      <= out_d;
      ones_q     <= ones_d;
    end
  end

  assign bus.rfd      = (rx_state_q == RX_WAIT);
  assign bus.dav_out_ = (tx_state_q != TX_VALID);
  assign bus.out      = out_q;
  assign bus.ones     = ones_q;

endmodule
